rv_test_monitor: RTL and testbench
==================================

# rv_test_monitor

- Synthesizable self-check monitor for the RV32I pipeline SoC.
- Snoops the register-file writeback port and detects the test-complete flag.
- Waits a settle window, then latches a PASS/FAIL/TIMEOUT verdict.
- Freezes a shadow copy of the architectural registers so the failing state can be read back after the run, in simulation or on FPGA.

## Interface
Parameters:
- DATA_W, default 32: writeback data width.
- DONE_REG, default 26: register index whose write of value 1 marks test completion.
- PASS_REG, default 27: register index that must hold 1 at the verdict for PASS.
- TNUM_REG, default 3: register index holding the current test number.
- SETTLE_CYCLES, default 10: cycles between the done write and the verdict. Legal range 1..65535.
- TIMEOUT_CYCLES, default 1000000: run cycles allowed before TIMEOUT. 0 disables the timeout.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-high reset.
- clr, input, 1: synchronous restart of the monitor.
- wb_we, input, 1: register-file write enable.
- wb_addr, input, 5: destination register index.
- wb_data, input, DATA_W: write data.
- dump_addr, input, 5: shadow register to read back.
- dump_data, output, DATA_W: shadow value at dump_addr, registered.
- done, output, 1: a verdict has been latched.
- pass, output, 1: the verdict is PASS.
- fail, output, 1: the verdict is FAIL.
- timeout, output, 1: the verdict is TIMEOUT.
- test_num, output, DATA_W: shadow of TNUM_REG.
- cycle_count, output, 32: cycles spent in RUN and SETTLE.

## Operation
States: RUN, SETTLE, PASS, FAIL, TIMEOUT.
- rst asserted: state goes to RUN immediately (asynchronous). All outputs, all 32 shadow registers, the settle counter and cycle_count are cleared to 0.

Shadow register file:
- Updated on every clk edge with wb_we=1 and wb_addr!=0 while in RUN or SETTLE.
- Writes to x0 are ignored; shadow[0] always reads 0.
- Frozen in PASS, FAIL and TIMEOUT.

State transitions:
- RUN → SETTLE: on a wb write to DONE_REG with wb_data==1. The settle counter loads SETTLE_CYCLES. A DONE_REG write with any other value only updates the shadow.
- RUN → TIMEOUT: when TIMEOUT_CYCLES!=0 and cycle_count reaches TIMEOUT_CYCLES−1 with no qualifying done write on that edge. A done write on the same edge wins, and the state goes to SETTLE.
- SETTLE: the counter decrements each cycle. A further DONE_REG write does not restart it. When the counter reaches 1, the next edge goes to PASS if shadow[PASS_REG]==1 (including a PASS_REG write on that same edge), otherwise to FAIL.
- PASS, FAIL, TIMEOUT: terminal until clr or rst.

Outputs:
- done=1 in the three terminal states.
- Exactly one of pass/fail/timeout is 1 when done=1; all are 0 otherwise.

cycle_count:
- Increments in RUN and SETTLE; holds in the terminal states.
- Saturates at 32'hFFFFFFFF.

clr:
- Acts like rst but synchronously, on the next edge.
- Priority: rst > clr > wb write. A wb write on the same edge as clr is discarded.

test_num:
- Continuously reflects shadow[TNUM_REG].

## Timing
- Shadow update: 1 cycle. A wb write sampled on edge N is visible on test_num and shadow readback after edge N.
- dump_data: registered read of the shadow. Value for dump_addr sampled on edge N is valid after edge N; legal in every state.
- Verdict latency: a done write sampled on edge N gives done=1 after edge N+SETTLE_CYCLES.
- A PASS_REG write up to and including edge N+SETTLE_CYCLES counts toward the verdict.
- Timeout: with no done write, timeout=1 after edge TIMEOUT_CYCLES counted from the first edge after rst deasserts.
- rst deasserted mid-SETTLE: the restart is clean; no partial verdict may appear.

## Test plan
- Pass: write x27=1, then x26=1, SETTLE_CYCLES=10 → done=pass=1 exactly 10 cycles after the x26 write; fail=timeout=0.
- Fail with dump: write x3=5, x27=0, x26=1 → fail=1, test_num=5. Sweep dump_addr 0..31 → values match the writes; dump_addr 0 reads 0.
- Late pass: write x26=1, then x27=1 at settle cycle 10 → pass=1. Write x27=1 one cycle later → state already FAIL and shadow frozen.
- Timeout: TIMEOUT_CYCLES=50, no writes → timeout=1 after 50 cycles, cycle_count=50. A done write on cycle 50 → SETTLE, not TIMEOUT.
- Ignored writes: x26=2, then x0=1 → state stays RUN, shadow[0]=0. A second x26=1 during SETTLE does not extend the verdict time.
- Reset/clear: rst pulsed mid-SETTLE → all outputs 0 asynchronously, no verdict appears. clr in PASS with simultaneous wb write → RUN next edge, shadow all 0, write discarded.

Source files
------------

// File: rtl/rv_test_monitor.sv
// rv_test_monitor: snoops RV32I writeback, shadows the register file and latches a PASS/FAIL/TIMEOUT verdict.
module rv_test_monitor #(
    parameter int          DATA_W         = 32,
    parameter int          DONE_REG       = 26,
    parameter int          PASS_REG       = 27,
    parameter int          TNUM_REG       = 3,
    parameter int          SETTLE_CYCLES  = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [4:0]        dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [DATA_W-1:0] test_num,
    output logic [31:0]       cycle_count
);
    typedef enum logic [2:0] {S_RUN, S_SETTLE, S_PASS, S_FAIL, S_TIMEOUT} state_t;
    localparam logic [15:0] SET_LD  = 16'(SETTLE_CYCLES);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    state_t state, next;
    logic [15:0] cnt;
    logic [DATA_W-1:0] shadow [32];
    logic live, wr, done_wr, pass_ok;
    assign live     = state == S_RUN || state == S_SETTLE;
    assign wr       = live && wb_we && wb_addr != 5'd0;
    assign done_wr  = wb_we && wb_addr == 5'(DONE_REG) && wb_data == DATA_W'(1);
    // a PASS_REG write on the verdict edge overrides the stored shadow value
    assign pass_ok  = (wr && wb_addr == 5'(PASS_REG)) ? wb_data == DATA_W'(1) : shadow[PASS_REG] == DATA_W'(1);
    assign done     = state == S_PASS || state == S_FAIL || state == S_TIMEOUT;
    assign pass     = state == S_PASS;
    assign fail     = state == S_FAIL;
    assign timeout  = state == S_TIMEOUT;
    assign test_num = shadow[TNUM_REG];
    always_comb begin
        next = state;
        case (state)
            S_RUN:    next = done_wr ? S_SETTLE :
                             (TIMEOUT_CYCLES != 0 && cycle_count == TO_LAST) ? S_TIMEOUT : S_RUN;
            S_SETTLE: next = cnt == 16'd1 ? (pass_ok ? S_PASS : S_FAIL) : S_SETTLE;
            default:  next = state;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_RUN;
            cnt         <= '0;
            cycle_count <= '0;
            dump_data   <= '0;
            for (int i = 0; i < 32; i++) shadow[i] <= '0;
        end else if (clr) begin
            state       <= S_RUN;
            cnt         <= '0;
            cycle_count <= '0;
            dump_data   <= '0;
            for (int i = 0; i < 32; i++) shadow[i] <= '0;
        end else begin
            state       <= next;
            cnt         <= state == S_RUN ? (done_wr ? SET_LD : cnt) :
                           state == S_SETTLE ? cnt - 16'd1 : cnt;
            cycle_count <= (live && cycle_count != 32'hFFFF_FFFF) ? cycle_count + 32'd1 : cycle_count;
            dump_data   <= shadow[dump_addr];
            if (wr) shadow[wb_addr] <= wb_data;
        end
    end
endmodule

// File: tb/tb_rv_test_monitor.sv
// tb_rv_test_monitor: table-driven and scoreboard checks of verdicts, shadow readback, timeout and restart.
module tb_rv_test_monitor;
    logic        clk = 0, rst = 1, clr = 0, wb_we = 0;
    logic [4:0]  wb_addr = 0, dump_addr = 0;
    logic [31:0] wb_data = 0, dump_data, test_num, cycle_count;
    logic        done, pass, fail, timeout;
    int checks = 0, errors = 0;
    logic [31:0] mdl [32];
    logic [31:0] sb [$];

    typedef struct {logic [4:0] addr; logic [31:0] data; logic [31:0] exp_tnum;} vec_t;
    vec_t vecs [10];

    rv_test_monitor #(.SETTLE_CYCLES(10), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst(rst), .clr(clr), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .dump_addr(dump_addr), .dump_data(dump_data), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .test_num(test_num), .cycle_count(cycle_count));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1; wb_addr = a; wb_data = d;
        tick();
        wb_we = 0;
        if (a != 0) mdl[a] = d;
    endtask

    task automatic do_clr();
        clr = 1;
        tick();
        clr = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 0;
    endtask

    task automatic verdict(input string name, input logic [3:0] exp);
        check({name, "_done"}, done, exp != 0);
        check({name, "_pft"}, {pass, fail, timeout}, exp[2:0]);
    endtask

    task automatic dump_sweep(input string name);
        for (int a = 0; a < 32; a++) begin
            dump_addr = 5'(a);
            sb.push_back(mdl[a]);
            tick();
            check(name, dump_data, sb.pop_front());
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 0;
        vecs[0] = '{5'd3,  32'd5,          32'd5};
        vecs[1] = '{5'd27, 32'd0,          32'd5};
        vecs[2] = '{5'd5,  32'hDEADBEEF,   32'd5};
        vecs[3] = '{5'd31, 32'h0000_1234,  32'd5};
        vecs[4] = '{5'd0,  32'd1,          32'd5};
        vecs[5] = '{5'd3,  32'd7,          32'd7};
        vecs[6] = '{5'd3,  32'd5,          32'd5};
        vecs[7] = '{5'd26, 32'd2,          32'd5};
        vecs[8] = '{5'd1,  32'hFFFF_FFFF,  32'd5};
        vecs[9] = '{5'd26, 32'd1,          32'd5};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        verdict("rst", 4'b0000);
        check("rst_tnum", test_num, 0);
        check("rst_cc", cycle_count, 0);
        check("rst_dump", dump_data, 0);
        rst = 0;

        // pass: verdict exactly 10 edges after the done write
        wb(27, 1);
        wb(26, 1);
        repeat (9) tick();
        verdict("pass_early", 4'b0000);
        tick();
        verdict("pass", 4'b1100);

        // fail with table-driven writes, then dump readback
        do_clr();
        foreach (vecs[i]) begin
            wb(vecs[i].addr, vecs[i].data);
            check($sformatf("vec%0d_tnum", i), test_num, vecs[i].exp_tnum);
            if (i < 9) check($sformatf("vec%0d_done", i), done, 0);
        end
        repeat (9) tick();
        verdict("fail_early", 4'b0000);
        tick();
        verdict("fail", 4'b1010);
        check("fail_tnum", test_num, 5);
        wb(3, 9);
        mdl[3] = 5;
        check("frozen_tnum", test_num, 5);
        dump_sweep("fail_dump");

        // late pass on the last settle edge
        do_clr();
        wb(26, 1);
        repeat (9) tick();
        wb(27, 1);
        verdict("late_pass", 4'b1100);
        // one edge too late: already FAIL and shadow frozen
        do_clr();
        wb(26, 1);
        repeat (10) tick();
        wb(27, 1);
        mdl[27] = 0;
        verdict("too_late", 4'b1010);
        dump_addr = 27;
        sb.push_back(mdl[27]);
        tick();
        check("too_late_x27", dump_data, sb.pop_front());

        // ignored writes and a second done during SETTLE
        do_clr();
        wb(26, 2);
        wb(0, 1);
        repeat (3) tick();
        verdict("ignored", 4'b0000);
        dump_addr = 0;
        sb.push_back(0);
        tick();
        check("x0_dump", dump_data, sb.pop_front());
        wb(26, 1);
        repeat (4) tick();
        wb(26, 1);
        repeat (4) tick();
        verdict("redone_early", 4'b0000);
        tick();
        verdict("redone", 4'b1010);

        // timeout after 50 cycles, count holds
        do_clr();
        repeat (49) tick();
        verdict("to_early", 4'b0000);
        check("to_cc49", cycle_count, 49);
        tick();
        verdict("to", 4'b1001);
        check("to_cc50", cycle_count, 50);
        repeat (5) tick();
        check("to_cc_hold", cycle_count, 50);

        // done write on the timeout edge wins
        do_clr();
        repeat (49) tick();
        wb(26, 1);
        verdict("to_race", 4'b0000);
        repeat (10) tick();
        verdict("to_race_end", 4'b1010);
        check("to_race_cc", cycle_count, 60);

        // asynchronous reset mid-SETTLE
        do_clr();
        wb(3, 4);
        wb(27, 1);
        wb(26, 1);
        repeat (3) tick();
        #2 rst = 1;
        #1;
        verdict("arst", 4'b0000);
        check("arst_tnum", test_num, 0);
        check("arst_cc", cycle_count, 0);
        tick();
        rst = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 0;
        repeat (15) tick();
        verdict("arst_after", 4'b0000);
        check("arst_cc15", cycle_count, 15);

        // clr in PASS with a simultaneous write that must be discarded
        do_clr();
        wb(27, 1);
        wb(3, 8);
        wb(26, 1);
        repeat (10) tick();
        verdict("pre_clr", 4'b1100);
        check("pre_clr_tnum", test_num, 8);
        clr = 1; wb_we = 1; wb_addr = 3; wb_data = 9;
        tick();
        clr = 0; wb_we = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 0;
        verdict("clr", 4'b0000);
        check("clr_tnum", test_num, 0);
        check("clr_cc", cycle_count, 0);
        dump_sweep("clr_dump");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
